codec_config_seq: RTL and testbench

Register-write sequencer that sits directly upstream of the I2C master in the microphone path. On `start` it walks a constant table of codec register writes and presents each one to the I2C master's write handshake. It waits for each transaction to finish, checks the master's NACK `error` flag, retries failed writes, and reports `done` or `fail` to the top level. It runs on the same 20 kHz I2C clock as the master.

---
 rtl/codec_config_pkg.sv | 45 ++++
 rtl/codec_config_rom.sv | 11 +
 rtl/codec_config_seq.sv | 136 +++++++++++++
 tb/tb_codec_config_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_config_pkg.sv
// Shared types and the WM8731 power-up register table for the codec configuration sequencer.
package codec_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  // WM8731 control word: 7-bit register number followed by 9-bit data.
  typedef struct packed {
    logic [6:0] reg_num;
    logic [8:0] data;
  } entry_t;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;

  function automatic entry_t mk_entry(logic [6:0] r, logic [8:0] d);
    return {r, d};
  endfunction

  localparam entry_t CODEC_INIT_TABLE [16] = '{
    mk_entry(7'h0F, 9'h000),
    mk_entry(7'h06, 9'h061),
    mk_entry(7'h04, 9'h014),
    mk_entry(7'h05, 9'h000),
    mk_entry(7'h07, 9'h042),
    mk_entry(7'h08, 9'h000),
    mk_entry(7'h00, 9'h017),
    mk_entry(7'h09, 9'h001),
    mk_entry(7'h00, 9'h000),
    mk_entry(7'h00, 9'h000),
    mk_entry(7'h00, 9'h000),
    mk_entry(7'h00, 9'h000),
    mk_entry(7'h00, 9'h000),
    mk_entry(7'h00, 9'h000),
    mk_entry(7'h00, 9'h000),
    mk_entry(7'h00, 9'h000)
  };

endpackage

// File: rtl/codec_config_rom.sv
// Index-to-entry lookup over the codec init table; swap this module to target another codec.
module codec_config_rom
  import codec_config_pkg::*;
(
  input  logic [3:0] index,
  output entry_t     entry
);

  assign entry = CODEC_INIT_TABLE[index];

endmodule

// File: rtl/codec_config_seq.sv
// Walks the codec register table through the I2C master's write handshake,
// retrying NACKed or timed-out writes and reporting sticky done/fail.
module codec_config_seq
  import codec_config_pkg::*;
#(
  parameter int         NUM_ENTRIES    = 8,
  parameter logic [6:0] SLAVE_ADDR     = WM8731_ADDR,
  parameter int         MAX_RETRIES    = 3,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [6:0] slav_addr,
  output logic       read_not_write,
  output logic [7:0] reg_addr,
  output logic [7:0] write_data,
  output logic       write_valid,
  input  logic       write_ready,
  input  logic       error,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] index,
  output logic [1:0] retries
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t           state;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       rom_index;
  entry_t           rom_entry;
  logic             in_wait, timeout, result_valid, check_now, check_nack;
  logic             last_entry, can_retry;

  // Outside GAP the only table fetch needed is entry 0 for a fresh start.
  assign rom_index = (state == ST_GAP) ? index : 4'd0;

  codec_config_rom u_rom (
    .index (rom_index),
    .entry (rom_entry)
  );

  assign in_wait      = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
  assign timeout      = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign result_valid = (state == ST_WAIT_DONE) && write_ready;
  assign check_now    = result_valid || timeout;
  assign check_nack   = !result_valid || error;
  assign last_entry   = (index == 4'(NUM_ENTRIES - 1));
  assign can_retry    = (int'(retries) < MAX_RETRIES) && (retries != 2'b11);

  assign busy = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
  assign read_not_write = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      index       <= 4'd0;
      retries     <= 2'd0;
      done        <= 1'b0;
      fail        <= 1'b0;
      write_valid <= 1'b0;
      reg_addr    <= 8'd0;
      write_data  <= 8'd0;
      slav_addr   <= SLAVE_ADDR;
    end else begin
      slav_addr <= SLAVE_ADDR;
      if (check_now) begin
        // A real NACK and a watchdog expiry share the same retry path.
        wd_cnt  <= '0;
        gap_cnt <= '0;
        if (!check_nack) begin
          if (last_entry) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            index   <= index + 4'd1;
            retries <= 2'd0;
            state   <= ST_GAP;
          end
        end else if (can_retry) begin
          retries <= retries + 2'd1;
          state   <= ST_GAP;
        end else begin
          state <= ST_FAIL;
          fail  <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
              state       <= ST_ISSUE;
              index       <= 4'd0;
              retries     <= 2'd0;
              done        <= 1'b0;
              fail        <= 1'b0;
              write_valid <= 1'b1;
              reg_addr    <= {rom_entry.reg_num, rom_entry.data[8]};
              write_data  <= rom_entry.data[7:0];
            end
          end
          ST_ISSUE: begin
            if (write_ready) begin
              write_valid <= 1'b0;
              wd_cnt      <= '0;
              state       <= ST_WAIT_BUSY;
            end
          end
          ST_WAIT_BUSY: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (!write_ready) state <= ST_WAIT_DONE;
          end
          ST_WAIT_DONE: wd_cnt <= wd_cnt + 1'b1;
          ST_GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              state       <= ST_ISSUE;
              write_valid <= 1'b1;
              reg_addr    <= {rom_entry.reg_num, rom_entry.data[8]};
              write_data  <= rom_entry.data[7:0];
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codec_config_seq.sv
// Randomised bench for codec_config_seq: a behavioural I2C master plus a transaction-level
// model of which table entry and retry count each write should carry.
module tb_codec_config_seq;

  localparam int NUM  = 8;
  localparam int MAXR = 3;
  localparam int TO   = 64;

  logic       clk = 1'b0;
  logic       reset, start, write_ready, error;
  logic [6:0] slav_addr;
  logic       read_not_write, write_valid, busy, done, fail;
  logic [7:0] reg_addr, write_data;
  logic [3:0] index;
  logic [1:0] retries;

  codec_config_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .slav_addr(slav_addr), .read_not_write(read_not_write),
    .reg_addr(reg_addr), .write_data(write_data),
    .write_valid(write_valid), .write_ready(write_ready), .error(error),
    .busy(busy), .done(done), .fail(fail), .index(index), .retries(retries)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // WM8731 table written as (register, 9-bit data) pairs.
  int ref_reg  [NUM] = '{'h0F, 'h06, 'h04, 'h05, 'h07, 'h08, 'h00, 'h09};
  int ref_data [NUM] = '{'h000, 'h061, 'h014, 'h000, 'h042, 'h000, 'h017, 'h001};

  // Transaction-level model state and master knobs.
  int exp_idx, exp_retry, exp_state, n_writes;
  int attempts [NUM];
  int nack_entry = -1, nack_times = 0, nack_pct = 0;
  bit hold = 1'b0, hang_next = 1'b0;
  int hs_cycle = 0;

  task automatic model_reset();
    exp_idx = 0; exp_retry = 0; exp_state = 0; n_writes = 0;
    for (int i = 0; i < NUM; i++) attempts[i] = 0;
  endtask

  initial begin : master_model
    bit nack, hang;
    int frame;
    write_ready = 1'b1;
    error = 1'b0;
    forever begin
      @(negedge clk);
      if (hold) begin
        write_ready = 1'b0;
      end else begin
        write_ready = 1'b1;
        if (write_valid) begin
          hs_cycle = cyc_cnt;
          n_writes++;
          check("write_after_end", exp_state, 0);
          check("wr_reg_addr", reg_addr, ref_reg[exp_idx] * 2 + ref_data[exp_idx] / 256);
          check("wr_data", write_data, ref_data[exp_idx] % 256);
          check("wr_slav_addr", slav_addr, 'h1A);
          check("wr_rnw", read_not_write, 0);
          check("wr_index", index, exp_idx);
          check("wr_retries", retries, exp_retry);
          hang = hang_next;
          hang_next = 1'b0;
          nack = hang || (exp_idx == nack_entry && attempts[exp_idx] < nack_times)
                 || ($urandom_range(0, 99) < nack_pct);
          attempts[exp_idx]++;
          $display("write #%0d entry %0d retry %0d reg_addr=%02h data=%02h %s",
                   n_writes, exp_idx, exp_retry, reg_addr, write_data,
                   hang ? "hang" : (nack ? "nack" : "ack"));
          if (!nack) begin
            if (exp_idx == NUM - 1) exp_state = 1;
            else begin exp_idx++; exp_retry = 0; end
          end else if (exp_retry < MAXR) exp_retry++;
          else exp_state = 2;
          frame = $urandom_range(2, 12);
          @(negedge clk);
          write_ready = 1'b0;
          if (hang) begin
            repeat (80) @(negedge clk);
          end else begin
            repeat (frame) @(negedge clk);
            write_ready = 1'b1;
            error = nack;
            @(negedge clk);
            error = 1'b0;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int c = 0;
    while (busy && c < 3000) begin @(negedge clk); c++; end
    check({tag, "_end_in_time"}, c < 3000, 1);
  endtask

  task automatic check_outcome(input string tag);
    check({tag, "_done"}, done, exp_state == 1);
    check({tag, "_fail"}, fail, exp_state == 2);
    check({tag, "_index"}, index, exp_idx);
    check({tag, "_busy"}, busy, 0);
    $display("run %s: writes=%0d done=%0d fail=%0d index=%0d", tag, n_writes, done, fail, index);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_index"}, index, 0);
    check({tag, "_retries"}, retries, 0);
    check({tag, "_valid"}, write_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_data"}, write_data, 0);
    check({tag, "_slav"}, slav_addr, 'h1A);
    check({tag, "_rnw"}, read_not_write, 0);
  endtask

  initial begin : global_watchdog
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c, vcount, delta;
    reset = 1'b1;
    start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run, with a start pulse mid-run that must be ignored.
    model_reset();
    pulse_start();
    c = 0;
    while (n_writes < 3 && c < 500) begin @(negedge clk); c++; end
    pulse_start();
    wait_end("clean");
    check("clean_writes", n_writes, 8);
    check_outcome("clean");

    // Handshake stall: ready held low while in ISSUE.
    model_reset();
    hold = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (write_valid && reg_addr == 8'h1E && write_data == 8'h00) vcount++;
    end
    check("stall_valid_held", vcount, 20);
    check("stall_no_write", n_writes, 0);
    hold = 1'b0;
    wait_end("stall");
    check("stall_writes", n_writes, 8);
    check_outcome("stall");

    // Single NACK on entry 2.
    model_reset();
    nack_entry = 2; nack_times = 1;
    pulse_start();
    wait_end("nack1");
    check("nack1_attempts", attempts[2], 2);
    check_outcome("nack1");

    // Persistent NACK on entry 4.
    model_reset();
    nack_entry = 4; nack_times = 99;
    pulse_start();
    wait_end("nackp");
    check("nackp_attempts", attempts[4], 4);
    check_outcome("nackp");
    vcount = 0;
    repeat (30) begin @(negedge clk); if (write_valid) vcount++; end
    check("nackp_quiet", vcount, 0);
    nack_entry = -1; nack_times = 0;

    // Master hangs after accepting entry 0: watchdog counts as a retry.
    model_reset();
    hang_next = 1'b1;
    pulse_start();
    c = 0;
    while (retries != 2'd1 && c < 300) begin @(negedge clk); c++; end
    check("timeout_seen", c < 300, 1);
    delta = cyc_cnt - hs_cycle - 1;
    check("timeout_cycles", delta, TO);
    check("timeout_no_fail", fail, 0);
    wait_end("timeout");
    check("timeout_attempts", attempts[0], 2);
    check_outcome("timeout");

    // Reset during entry 3, then a fresh run.
    model_reset();
    pulse_start();
    c = 0;
    while (index != 4'd3 && c < 500) begin @(negedge clk); c++; end
    check("rst_reached_entry3", c < 500, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    pulse_start();
    wait_end("rerun");
    check("rerun_writes", n_writes, 8);
    check_outcome("rerun");

    // Randomised NACK pattern runs.
    nack_pct = 15;
    for (int r = 0; r < 6; r++) begin
      model_reset();
      pulse_start();
      wait_end($sformatf("rand%0d", r));
      check_outcome($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
